// File: rtl/div_if.sv
// Handshake and write-back bundle between the execute stage and the divide unit.
interface div_if #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned RF_ADDR_LEN = 5
);
    logic                   start;
    logic [1:0]             op;
    logic [DATA_LEN-1:0]    rs1_data;
    logic [DATA_LEN-1:0]    rs2_data;
    logic [RF_ADDR_LEN-1:0] rd_addr_in;
    logic                   busy;
    logic                   done;
    logic                   w_en;
    logic [RF_ADDR_LEN-1:0] rd_addr;
    logic [DATA_LEN-1:0]    rd_write_data;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr_in,
        input  busy, done, w_en, rd_addr, rd_write_data
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr_in,
        output busy, done, w_en, rd_addr, rd_write_data
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per cycle,
// single registered write-back beat to the register file.
module div_unit #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned RF_ADDR_LEN = 5
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_LEN);
    localparam logic [DATA_LEN-1:0] MinNeg = {1'b1, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [DATA_LEN-1:0]    quo_q, quo_d;
    logic [DATA_LEN-1:0]    rem_q, rem_d;
    logic [DATA_LEN-1:0]    divisor_q, divisor_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [RF_ADDR_LEN-1:0] rd_lat_q, rd_lat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [RF_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_LEN-1:0]    data_q, data_d;

    logic                in_signed;
    logic                a_neg, b_neg;
    logic [DATA_LEN-1:0] a_abs, b_abs;
    logic [DATA_LEN:0]   trial, diff;
    logic [DATA_LEN-1:0] quo_fix, rem_fix;

    assign in_signed = ~bus.op[0];
    assign a_neg     = in_signed & bus.rs1_data[DATA_LEN-1];
    assign b_neg     = in_signed & bus.rs2_data[DATA_LEN-1];
    // Negating MinNeg wraps to itself, which reads correctly as unsigned 2^(DATA_LEN-1).
    assign a_abs     = a_neg ? -bus.rs1_data : bus.rs1_data;
    assign b_abs     = b_neg ? -bus.rs2_data : bus.rs2_data;

    assign trial   = {rem_q, quo_q[DATA_LEN-1]};
    assign diff    = trial - {1'b0, divisor_q};
    assign quo_fix = qneg_q ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        cnt_d     = cnt_q;
        rd_lat_d  = rd_lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    rd_lat_d  = bus.rd_addr_in;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    divisor_d = b_abs;
                    if (bus.rs2_data == '0) begin
                        quo_d   = '1;
                        rem_d   = bus.rs1_data;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = StFinish;
                    end else if (in_signed && bus.rs1_data == MinNeg && bus.rs2_data == '1) begin
                        quo_d   = bus.rs1_data;
                        rem_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = StFinish;
                    end else begin
                        quo_d   = a_abs;
                        rem_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
                if (!diff[DATA_LEN]) begin
                    rem_d = diff[DATA_LEN-1:0];
                    quo_d = {quo_q[DATA_LEN-2:0], 1'b1};
                end else begin
                    rem_d = trial[DATA_LEN-1:0];
                    quo_d = {quo_q[DATA_LEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DATA_LEN - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                data_d    = op_q[1] ? rem_fix : quo_fix;
                rd_addr_d = rd_lat_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            cnt_q     <= '0;
            rd_lat_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            cnt_q     <= cnt_d;
            rd_lat_q  <= rd_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.w_en          = done_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.rd_write_data = data_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, busy length, special cases,
// ignored start, reset abort and back-to-back throughput.
module tb_div_unit;
    localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ecount = 0;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op; optionally poke a conflicting start at iteration poke_at.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                         input logic [31:0] exp_data, input int poke_at);
        int  lat;
        int  nb;
        bit  seen;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op         = o;
        bus.rs1_data   = a;
        bus.rs2_data   = b;
        bus.rd_addr_in = rd;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat  = 0;
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.w_en) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            if (lat == poke_at) begin
                bus.start      = 1'b1;
                bus.op         = OpDivu;
                bus.rs1_data   = 32'd9;
                bus.rs2_data   = 32'd3;
                bus.rd_addr_in = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            lat++;
        end
        check_eq({tag, "_wen_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
        check_eq({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(rd));
        check_eq({tag, "_data"}, 64'(bus.rd_write_data), 64'(exp_data));
        @(negedge clk);
        check_eq({tag, "_wen_one_cycle"}, 64'(bus.w_en), 64'd0);
    endtask

    initial begin
        int w1;
        int w2;
        bit got;
        bus.start      = 1'b0;
        bus.op         = '0;
        bus.rs1_data   = '0;
        bus.rs2_data   = '0;
        bus.rd_addr_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_wen", 64'(bus.w_en), 64'd0);
        check_eq("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        check_eq("rst_data", 64'(bus.rd_write_data), 64'd0);
        rst = 1'b0;

        do_op("divu_100_7", OpDivu, 32'd100, 32'd7, 5'd5, 33, 32'd14, -1);
        do_op("remu_100_7", OpRemu, 32'd100, 32'd7, 5'd6, 33, 32'd2, -1);
        do_op("div_m7_2",   OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd1, 33, 32'hFFFF_FFFD, -1);
        do_op("rem_m7_2",   OpRem, 32'hFFFF_FFF9, 32'd2, 5'd2, 33, 32'hFFFF_FFFF, -1);
        do_op("div_7_m2",   OpDiv, 32'd7, 32'hFFFF_FFFE, 5'd3, 33, 32'hFFFF_FFFD, -1);
        do_op("rem_7_m2",   OpRem, 32'd7, 32'hFFFF_FFFE, 5'd4, 33, 32'd1, -1);
        do_op("div_5_0",    OpDiv, 32'd5, 32'd0, 5'd7, 1, 32'hFFFF_FFFF, -1);
        do_op("divu_5_0",   OpDivu, 32'd5, 32'd0, 5'd8, 1, 32'hFFFF_FFFF, -1);
        do_op("rem_5_0",    OpRem, 32'd5, 32'd0, 5'd0, 1, 32'd5, -1);
        do_op("div_ovf",    OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'h8000_0000, -1);
        do_op("rem_ovf",    OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'd0, -1);
        do_op("divu_ovf",   OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 33, 32'd0, -1);
        do_op("ignored_start", OpDivu, 32'd1000, 32'd10, 5'd7, 33, 32'd100, 5);

        // Reset abort at iteration 10.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = OpDivu;
        bus.rs1_data = 32'd1000;
        bus.rs2_data = 32'd10;
        bus.rd_addr_in = 5'd15;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_wen", 64'(bus.w_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.w_en) got = 1'b1;
        end
        check_eq("abort_no_wen", 64'(got), 64'd0);
        do_op("divu_9_3", OpDivu, 32'd9, 32'd3, 5'd9, 33, 32'd3, -1);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op         = OpDivu;
        bus.rs1_data   = 32'd20;
        bus.rs2_data   = 32'd4;
        bus.rd_addr_in = 5'd10;
        @(negedge clk);
        bus.rs1_data   = 32'd21;
        bus.rd_addr_in = 5'd11;
        w1  = -1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.w_en) begin
                got = 1'b1;
                w1  = ecount;
                break;
            end
            @(negedge clk);
        end
        check_eq("b2b_first_seen", 64'(got), 64'd1);
        check_eq("b2b_first_rd", 64'(bus.rd_addr), 64'd10);
        check_eq("b2b_first_data", 64'(bus.rd_write_data), 64'd5);
        @(negedge clk);
        bus.start = 1'b0;
        w2  = -1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.w_en) begin
                got = 1'b1;
                w2  = ecount;
                break;
            end
        end
        check_eq("b2b_second_seen", 64'(got), 64'd1);
        check_eq("b2b_gap", 64'(w2 - w1), 64'd34);
        check_eq("b2b_second_rd", 64'(bus.rd_addr), 64'd11);
        check_eq("b2b_second_data", 64'(bus.rd_write_data), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit in the execute stage. It sits between the register file's read ports and its write port. It takes `rs1_data`/`rs2_data` operands plus a destination address, computes DIV/DIVU/REM/REMU one quotient bit per cycle, and issues exactly one write-back beat (`w_en`, `rd_addr`, `rd_write_data`) that connects directly to the register file's write port.

## Interface
- `DATA_LEN`, default 32: operand/result width; must be ≥ 2.
- `RF_ADDR_LEN`, default 5: register address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data`  in  DATA_LEN  dividend.
- `rs2_data`  in  DATA_LEN  divisor.
- `rd_addr_in`  in  RF_ADDR_LEN  destination register.
- `busy`  out  1  high in CALC and FINISH.
- `done`  out  1  one-cycle completion pulse.
- `w_en`  out  1  register-file write enable; identical to `done`.
- `rd_addr`  out  RF_ADDR_LEN  write address.
- `rd_write_data`  out  DATA_LEN  result.

## Operation
- All outputs are registered.
- Reset values: `busy`, `done`, `w_en`, `rd_addr`, and `rd_write_data` are all 0; the state is IDLE.
- The FSM has three states:
  - IDLE: no operation in progress.
  - CALC: iterating.
  - FINISH: sign fix-up.
- IDLE, on `start`=1:
  - latch `op`, the operands, and `rd_addr_in`;
  - go to CALC with iteration count 0, or go directly to FINISH on a special case.
- Special cases are checked on the raw operands at accept time:
  - Divisor = 0: quotient = all ones; remainder = dividend. This applies to signed and unsigned ops.
  - Signed overflow (DIV/REM only, dividend = 100…0 and divisor = all ones): quotient = dividend; remainder = 0.
- Signed ops (DIV/REM) divide the absolute values. Negating the most-negative value yields the same bit pattern, which is treated as unsigned 2^(DATA_LEN-1).
- CALC performs restoring division, one bit per edge, using a DATA_LEN+1-bit partial remainder. It runs exactly DATA_LEN iterations, then goes to FINISH.
- FINISH, on the next edge:
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend (signed ops only).
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU) into `rd_write_data`.
  - Copy the latched destination to `rd_addr`.
  - Set `done`=`w_en`=1 and return to IDLE.
- `done` and `w_en` clear on the following edge.
- `rd_write_data` and `rd_addr` hold their values until the next completion.
- `start` while `busy`=1 is ignored. Operand changes while busy have no effect.
- `rd_addr_in`=0 is still written back; discarding the write is the register file's job.
- `rst` asserted mid-operation:
  - Outputs go to their reset values immediately and the state goes to IDLE.
  - No write is issued for the aborted operation.

## Timing
- Let E0 be the edge that accepts `start`.
- Normal ops:
  - `busy` is high from after E0 until E(DATA_LEN+1).
  - `done`/`w_en` are high for exactly the cycle between E(DATA_LEN+1) and E(DATA_LEN+2).
  - Latency is DATA_LEN+1 edges (33 for DATA_LEN=32).
- Special cases:
  - E0 goes directly to FINISH.
  - `done`/`w_en` are high between E1 and E2; latency is 1 edge.
- Back-to-back: the unit is in IDLE while `done`=1, so a `start` held high during the done cycle is accepted at E(DATA_LEN+2). The throughput gap is zero.
- No combinational path exists from any input to any output.

## Test plan
- DIVU 100/7, rd=5, then REMU 100/7, rd=6:
  - DIVU: `w_en` is high for exactly one cycle, 33 edges after accept, with `rd_addr`=5 and data=14.
  - REMU: `rd_addr`=6 and data=2.
  - `busy` is high for exactly 33 cycles per op.
- Signed results: each of the following completes after 33 edges.
  - DIV −7/2 gives 0xFFFFFFFD.
  - REM −7/2 gives 0xFFFFFFFF.
  - DIV 7/−2 gives 0xFFFFFFFD.
  - REM 7/−2 gives 1.
- Divide by zero: each of the following has `w_en` one edge after accept.
  - DIV 5/0 gives 0xFFFFFFFF.
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000, with latency 1.
  - REM of the same operands gives 0.
  - DIVU 0x80000000/0xFFFFFFFF takes the normal path (33 edges) and gives 0.
- Ignored start and reset abort:
  - Pulse `start` with new operands at iteration 5: it is ignored, and the first result is unaffected.
  - Assert `rst` at iteration 10: `busy`=0 immediately and no `w_en` follows.
  - After deasserting `rst`, DIVU 9/3 gives 3.
- Back-to-back: hold `start`=1 across two DIVU ops (20/4, then 21/4).
  - Results are 5, then 5.
  - The two `w_en` pulses are exactly 34 edges apart, and `rd_addr` tracks each latched destination.
